// File: rtl/fetch_branch_unit.sv
// ----------------------------------------------------------------------------
// fetch_branch_unit
//
// Front end of the 32-bit RISC core. This block owns the program counter. It
// fetches one instruction at a time from instruction memory over a req/ack
// handshake and holds that word for the decoder. When execute reports
// completion, it picks the next PC from the decoder's branch controls and
// the architectural E/GT flags. The E/GT flags are also held here and are
// written by cmp.
//
// Per-instruction flow:
//   IDLE  --run-->  FETCH  --ack-->  ISSUE  --exec_done-->  FETCH / IDLE
//                     |
//                     +--no ack for TIMEOUT cycles-->  ERR (left only by reset)
//
// Parameters
//   RESET_PC  PC loaded on reset
//   TIMEOUT   FETCH cycles without an ack before a fetch error (>= 1)
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   run                     allows new fetches (sampled in IDLE and at exec_done)
//   imem_req/addr           fetch request and address (= pc), held until ack
//   imem_ack/rdata          one-cycle ack; the instruction word is valid with it
//   inst, opcode, i_bit     latched instruction and the fields the decoder uses
//   inst_valid              an instruction is held and is waiting for execute
//   exec_done               one-cycle pulse: execute of the held inst is done
//   isbeq/isbgt/isubranch/isret, ret_addr   branch controls for the held inst
//   flag_wr, flag_e_in, flag_gt_in          cmp results, qualified by exec_done
//   flag_e, flag_gt         architectural flags
//   pc, instr_count         current PC and retired-instruction count
//   fetch_err               sticky fetch-timeout error
// ----------------------------------------------------------------------------
module fetch_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [4:0]  opcode,
  output logic        i_bit,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic        isbeq,
  input  logic        isbgt,
  input  logic        isubranch,
  input  logic        isret,
  input  logic [31:0] ret_addr,
  input  logic        flag_wr,
  input  logic        flag_e_in,
  input  logic        flag_gt_in,
  output logic        flag_e,
  output logic        flag_gt,
  output logic [31:0] pc,
  output logic [31:0] instr_count,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  // The wait counter only has to reach TIMEOUT-1. A FETCH cycle that starts
  // with that count and still has no ack is the last one allowed.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q,  state_d;
  logic [31:0]   pc_q,     pc_d;
  logic [31:0]   inst_q,   inst_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          flag_e_q, flag_e_d;
  logic          flag_gt_q, flag_gt_d;
  logic [31:0]   count_q,  count_d;
  logic          err_q,    err_d;

  // --------------------------------------------------------------------------
  // Next-PC selection. This only matters in the exec_done cycle. It uses the
  // registered flags, so a cmp that retires together with a branch does not
  // affect that branch.
  // --------------------------------------------------------------------------
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] seq_pc;
  logic [31:0] ret_target;
  logic        br_taken;
  logic [31:0] next_pc;

  // inst[26:0] is a signed word offset. It is sign-extended and scaled to bytes.
  assign br_offset  = {{3{inst_q[26]}}, inst_q[26:0], 2'b00};
  assign br_target  = pc_q + br_offset;
  assign seq_pc     = pc_q + 32'd4;
  // Returns always land on a word boundary.
  assign ret_target = ret_addr & 32'hFFFF_FFFC;
  assign br_taken   = isubranch | (isbeq & flag_e_q) | (isbgt & flag_gt_q);

  always_comb begin
    if (isret) begin
      next_pc = ret_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end else begin
      next_pc = seq_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first. This keeps the
    // block purely combinational on every path, so no latch is inferred.
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    cnt_d     = cnt_q;
    flag_e_d  = flag_e_q;
    flag_gt_d = flag_gt_q;
    count_d   = count_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end

      S_FETCH: begin
        // An ack in the last allowed cycle still counts, because it is
        // checked before the timeout.
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_ISSUE: begin
        if (exec_done) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          if (flag_wr) begin
            flag_e_d  = flag_e_in;
            flag_gt_d = flag_gt_in;
          end
          if (run) begin
            state_d = S_FETCH;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_ERR: begin
        // Nothing changes here. Only reset leaves this state.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples the values from before the clock edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      cnt_q     <= '0;
      flag_e_q  <= 1'b0;
      flag_gt_q <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      cnt_q     <= cnt_d;
      flag_e_q  <= flag_e_d;
      flag_gt_q <= flag_gt_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. These are taken straight from registers or registered state, so
  // the request and valid signals never glitch with the inputs.
  // --------------------------------------------------------------------------
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign inst        = inst_q;
  assign opcode      = inst_q[31:27];
  assign i_bit       = inst_q[26];
  assign inst_valid  = (state_q == S_ISSUE);
  assign flag_e      = flag_e_q;
  assign flag_gt     = flag_gt_q;
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_branch_unit
//
// Directed vector table (hand-computed next PCs and flags), hand-written
// reset/timeout/idle sequences, then randomized instructions checked against
// an arithmetic next-PC reference model.
// ----------------------------------------------------------------------------
module tb_fetch_branch_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [4:0]  opcode;
  logic        i_bit;
  logic        inst_valid;
  logic        exec_done;
  logic        isbeq, isbgt, isubranch, isret;
  logic [31:0] ret_addr;
  logic        flag_wr, flag_e_in, flag_gt_in;
  logic        flag_e, flag_gt;
  logic [31:0] pc;
  logic [31:0] instr_count;
  logic        fetch_err;

  fetch_branch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .opcode      (opcode),
    .i_bit       (i_bit),
    .inst_valid  (inst_valid),
    .exec_done   (exec_done),
    .isbeq       (isbeq),
    .isbgt       (isbgt),
    .isubranch   (isubranch),
    .isret       (isret),
    .ret_addr    (ret_addr),
    .flag_wr     (flag_wr),
    .flag_e_in   (flag_e_in),
    .flag_gt_in  (flag_gt_in),
    .flag_e      (flag_e),
    .flag_gt     (flag_gt),
    .pc          (pc),
    .instr_count (instr_count),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        beq, bgt, ubr, ret;
    logic [31:0] ret_addr;
    logic        fwr, fe, fgt;
    int          ackd;     // request cycles without ack before the ack cycle
    bit          stray;    // inject ignored ack/flag/branch inputs in ISSUE
    logic [31:0] exp_pc;
    logic        exp_e, exp_gt;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cur_pc;
  logic        cur_e, cur_gt;
  logic [31:0] exp_count;
  vec_t        tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] iw, input logic beq, bgt, ubr, ret,
                              input logic [31:0] ra, input logic fwr, fe, fgt,
                              input int ackd, input bit stray,
                              input logic [31:0] epc, input logic ee, egt);
    vec_t v;
    v.inst = iw; v.beq = beq; v.bgt = bgt; v.ubr = ubr; v.ret = ret;
    v.ret_addr = ra; v.fwr = fwr; v.fe = fe; v.fgt = fgt;
    v.ackd = ackd; v.stray = stray;
    v.exp_pc = epc; v.exp_e = ee; v.exp_gt = egt;
    return v;
  endfunction

  // Reference next PC: signed word offset scaled to bytes, plain 64-bit math.
  function automatic logic [31:0] ref_next(input logic [31:0] pc_v, input logic [31:0] iw,
                                           input logic beq, bgt, ubr, ret,
                                           input logic [31:0] ra, input logic e, gt);
    logic signed [26:0] words;
    longint             disp;
    words = iw[26:0];
    disp  = longint'(words) * 4;
    if (ret) return ra - (ra % 4);
    if (ubr || (beq && e) || (bgt && gt)) return 32'(longint'(pc_v) + disp);
    return pc_v + 32'd4;
  endfunction

  task automatic clear_ctrl();
    imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
    isbeq = 1'b0; isbgt = 1'b0; isubranch = 1'b0; isret = 1'b0; ret_addr = '0;
    flag_wr = 1'b0; flag_e_in = 1'b0; flag_gt_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    clear_ctrl();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_pc = '0; cur_e = 1'b0; cur_gt = 1'b0; exp_count = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},          pc,          32'h0);
    check({tag, "_imem_req"},    imem_req,    1'b0);
    check({tag, "_inst"},        inst,        32'h0);
    check({tag, "_inst_valid"},  inst_valid,  1'b0);
    check({tag, "_flags"},       {flag_e, flag_gt}, 2'b00);
    check({tag, "_instr_count"}, instr_count, 32'h0);
    check({tag, "_fetch_err"},   fetch_err,   1'b0);
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", imem_req, 1'b1);
    ok = imem_req;
  endtask

  // Fetch, optionally disturb, execute and check one instruction. We enter
  // with the DUT in FETCH or about to enter it, and sample on negedges.
  task automatic run_inst(input vec_t v, input logic run_after);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    check("fetch_addr", imem_addr, cur_pc);
    repeat (v.ackd) @(negedge clk);
    check("req_held", imem_req, 1'b1);
    check("fetch_err_pre", fetch_err, 1'b0);
    imem_ack   = 1'b1;
    imem_rdata = v.inst;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check("inst_valid", inst_valid, 1'b1);
    check("inst", inst, v.inst);
    check("opcode", opcode, v.inst[31:27]);
    check("i_bit", i_bit, v.inst[26]);
    check("req_drop", imem_req, 1'b0);
    if (v.stray) begin
      imem_ack = 1'b1; imem_rdata = ~v.inst;
      isubranch = 1'b1; isret = 1'b1; ret_addr = 32'h0000_0400;
      flag_wr = 1'b1; flag_e_in = ~cur_e; flag_gt_in = ~cur_gt;
      @(negedge clk);
      clear_ctrl();
      check("stray_inst", inst, v.inst);
      check("stray_valid", inst_valid, 1'b1);
      check("stray_pc", pc, cur_pc);
      check("stray_flags", {flag_e, flag_gt}, {cur_e, cur_gt});
    end
    isbeq = v.beq; isbgt = v.bgt; isubranch = v.ubr; isret = v.ret;
    ret_addr = v.ret_addr;
    flag_wr = v.fwr; flag_e_in = v.fe; flag_gt_in = v.fgt;
    exec_done = 1'b1;
    run = run_after;
    @(negedge clk);
    clear_ctrl();
    exp_count = exp_count + 32'd1;
    check("pc", pc, v.exp_pc);
    check("instr_count", instr_count, exp_count);
    check("flag_e", flag_e, v.exp_e);
    check("flag_gt", flag_gt, v.exp_gt);
    check("valid_clr", inst_valid, 1'b0);
    check("req_next", imem_req, run_after);
    cur_pc = v.exp_pc; cur_e = v.exp_e; cur_gt = v.exp_gt;
  endtask

  initial begin
    bit   ok;
    int   n;
    vec_t v;
    logic ra;

    reset = 1'b1;
    run   = 1'b0;
    clear_ctrl();

    //          inst          beq bgt ubr ret ret_addr       fwr fe fgt ackd stray exp_pc          e  gt
    tbl[0]  = mk(32'h6800_0000, 0, 0, 0, 0, 32'h0,          0, 0, 0,  2, 0, 32'h0000_0004, 0, 0);
    tbl[1]  = mk(32'h0000_0000, 0, 0, 0, 0, 32'h0,          1, 1, 0,  0, 0, 32'h0000_0008, 1, 0);
    tbl[2]  = mk(32'h8000_0004, 1, 0, 0, 0, 32'h0,          0, 0, 0,  1, 0, 32'h0000_0018, 1, 0);
    tbl[3]  = mk(32'h0000_0000, 0, 0, 0, 0, 32'h0,          1, 0, 0,  3, 0, 32'h0000_001C, 0, 0);
    tbl[4]  = mk(32'h8000_0004, 1, 0, 0, 0, 32'h0,          0, 0, 0,  0, 0, 32'h0000_0020, 0, 0);
    tbl[5]  = mk(32'h0000_0000, 0, 0, 0, 1, 32'h0000_0100,  0, 0, 0,  0, 0, 32'h0000_0100, 0, 0);
    tbl[6]  = mk(32'h07FF_FFFF, 0, 0, 1, 0, 32'h0,          0, 0, 0,  0, 0, 32'h0000_00FC, 0, 0);
    tbl[7]  = mk(32'h0000_0000, 0, 0, 0, 1, 32'hFFFF_FFFF,  0, 0, 0,  0, 0, 32'hFFFF_FFFC, 0, 0);
    tbl[8]  = mk(32'h0000_0005, 0, 0, 0, 0, 32'h0,          0, 0, 0,  0, 0, 32'h0000_0000, 0, 0);
    tbl[9]  = mk(32'h0000_0010, 0, 0, 1, 1, 32'h0000_0203,  0, 0, 0,  0, 0, 32'h0000_0200, 0, 0);
    tbl[10] = mk(32'h0000_0008, 0, 1, 0, 0, 32'h0,          1, 0, 1,  0, 0, 32'h0000_0204, 0, 1);
    tbl[11] = mk(32'h0400_0000, 0, 1, 0, 0, 32'h0,          0, 0, 0,  0, 0, 32'hF000_0204, 0, 1);
    tbl[12] = mk(32'h0000_0003, 1, 1, 0, 0, 32'h0,          0, 0, 0, 15, 0, 32'hF000_0210, 0, 1);
    tbl[13] = mk(32'hF800_0003, 1, 0, 0, 0, 32'h0,          0, 0, 0,  4, 1, 32'hF000_0214, 0, 1);

    // Reset state, then the directed table, run back-to-back.
    do_reset();
    check_reset_vals("reset");
    run = 1'b1;
    for (int i = 0; i < 14; i++) run_inst(tbl[i], 1'b1);

    // Reset in the middle of a FETCH with nonzero pc, count and flags.
    wait_req(ok);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_fetch");
    do_reset();

    // Reset in the middle of an ISSUE.
    run = 1'b1;
    run_inst(mk(32'h0000_0000, 0, 0, 0, 0, 32'h0, 1, 1, 1, 0, 0, 32'h4, 1, 1), 1'b1);
    wait_req(ok);
    imem_ack = 1'b1; imem_rdata = 32'h6800_0000;
    @(negedge clk);
    imem_ack = 1'b0;
    check("issue_before_rst", inst_valid, 1'b1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_issue");
    do_reset();

    // run=0 at exec_done: return to IDLE and issue no request.
    run = 1'b1;
    run_inst(mk(32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h4, 0, 0), 1'b0);
    repeat (5) @(negedge clk);
    check("idle_req", imem_req, 1'b0);
    check("idle_valid", inst_valid, 1'b0);
    check("idle_pc", pc, 32'h4);

    // Fetch timeout: 16 request cycles, then ERR. ERR ignores later acks.
    do_reset();
    run = 1'b1;
    wait_req(ok);
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", n, 16);
    check("timeout_err", fetch_err, 1'b1);
    check("timeout_req", imem_req, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("err_hold_req", imem_req, 1'b0);
    check("err_hold_valid", inst_valid, 1'b0);
    check("err_hold_flag", fetch_err, 1'b1);
    check("err_hold_inst", inst, 32'h0);
    check("err_hold_pc", pc, 32'h0);

    // Randomized instructions against the reference model.
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 150; k++) begin
      v.inst     = $urandom;
      v.beq      = ($urandom_range(0, 2) == 0);
      v.bgt      = ($urandom_range(0, 2) == 0);
      v.ubr      = ($urandom_range(0, 4) == 0);
      v.ret      = ($urandom_range(0, 7) == 0);
      v.ret_addr = $urandom;
      v.fwr      = ($urandom_range(0, 1) == 1);
      v.fe       = ($urandom_range(0, 1) == 1);
      v.fgt      = ($urandom_range(0, 1) == 1);
      v.ackd     = $urandom_range(0, 15);
      v.stray    = ($urandom_range(0, 7) == 0);
      v.exp_pc   = ref_next(cur_pc, v.inst, v.beq, v.bgt, v.ubr, v.ret,
                            v.ret_addr, cur_e, cur_gt);
      v.exp_e    = v.fwr ? v.fe  : cur_e;
      v.exp_gt   = v.fwr ? v.fgt : cur_gt;
      ra         = ($urandom_range(0, 9) != 0);
      run_inst(v, ra);
      if (!ra) begin
        repeat (3) @(negedge clk);
        check("rand_idle_req", imem_req, 1'b0);
        run = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_branch_unit.md
Name: fetch_branch_unit

Overview:
- Front end of the 32-bit RISC core and the counterpart to the instruction decoder.
- Owns the PC, fetches instructions from instruction memory over a req/ack handshake, and presents opcode and immediate-bit fields to the decoder.
- Consumes the decoder's branch controls (isbeq, isbgt, isubranch, isret) plus execute-stage results to select the next PC.
- Holds the architectural E/GT flags written by cmp.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles waiting for imem_ack before fetch error (min 1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  permits new fetches; sampled in IDLE and at exec_done
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  one-cycle ack; imem_rdata valid same cycle
imem_rdata  in  32  instruction word
inst  out  32  latched instruction
opcode  out  5  inst[31:27], to decoder
i_bit  out  1  inst[26], to decoder
inst_valid  out  1  inst held, awaiting execute
exec_done  in  1  one-cycle pulse: execute of current inst complete
isbeq, isbgt, isubranch, isret  in  1 each  decoder branch controls for current inst
ret_addr  in  32  return-address register value (for ret)
flag_wr  in  1  cmp result valid with exec_done
flag_e_in, flag_gt_in  in  1 each  cmp results
flag_e, flag_gt  out  1 each  registered flags
pc  out  32  current PC
instr_count  out  32  retired instruction count
fetch_err  out  1  sticky fetch-timeout error

Behaviour:
- Reset (async, any state, mid-handshake included) values:
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, inst=0, inst_valid=0.
  - flag_e=flag_gt=0, instr_count=0, fetch_err=0, timeout counter=0.
- States: IDLE, FETCH, ISSUE, ERR.
- IDLE:
  - run=1 → FETCH; imem_req=1 from next cycle.
  - run=0 → stay.
- FETCH:
  - imem_req=1, imem_addr=pc, both stable until ack.
  - On imem_ack: inst<=imem_rdata, imem_req<=0, → ISSUE; inst_valid=1 the cycle after ack.
  - Counter increments each FETCH cycle without ack. Counter reaching TIMEOUT with no ack → ERR, imem_req<=0, fetch_err<=1.
  - Ack on exactly cycle TIMEOUT is accepted (ack wins).
  - Counter clears on entering FETCH.
- ISSUE:
  - inst_valid=1; opcode/i_bit driven combinationally from inst.
  - On exec_done: pc<=next_pc, instr_count<=instr_count+1 (wraps at 2^32), inst_valid<=0.
  - Then run=1 → FETCH (req next cycle, back-to-back); run=0 → IDLE.
- ERR: all outputs hold; exits only via reset.
- Ignored inputs:
  - imem_ack outside FETCH.
  - exec_done outside ISSUE.
  - branch controls and flag inputs without exec_done.
- next_pc priority (evaluated at exec_done):
  - isret → {ret_addr[31:2],2'b00}
  - isubranch → target
  - isbeq & flag_e → target
  - isbgt & flag_gt → target
  - else pc+4, modulo 2^32.
- target = pc + {{3{inst[26]}}, inst[26:0], 2'b00}, modulo 2^32. Offset is a signed word offset.
- Flags:
  - flag_wr with exec_done → flag_e<=flag_e_in, flag_gt<=flag_gt_in.
  - A branch in the same exec_done cycle as flag_wr uses the old registered flags.
- Minimum latency per instruction: request cycle + ack cycle + 1 ISSUE cycle + exec_done.

Test Plan:
- Reset, run=1, ack 2 cycles after req with 32'h6800_0000 → imem_addr=0; inst_valid=1 cycle after ack; opcode=5'b01101; exec_done → pc=4, instr_count=1, imem_req reasserted next cycle.
- Flag update then branch:
  - cmp with flag_wr, flag_e_in=1 → flag_e=1.
  - Next inst 32'h8000_0004 at pc=8 with isbeq → pc=8+16=24.
  - Repeat with flag_e=0 → pc=12.
- Backward branch: pc=32'h100, isubranch, inst[26:0]=27'h7FF_FFFF → pc=32'hFC. pc=32'hFFFF_FFFC non-branch → pc=0 (wrap).
- Priority: isret and isubranch both set, ret_addr=32'h203 → pc=32'h200. isbgt with flag_gt=0 and concurrent flag_wr gt_in=1 → not taken, flag_gt=1 afterwards.
- Timeout: no ack with TIMEOUT=16 → ERR after 16 request cycles, fetch_err=1, imem_req=0. Ack at cycle 16 in a separate run → accepted. Stray ack in ISSUE ignored.
- Reset asserted mid-FETCH and mid-ISSUE → all outputs return to reset values immediately; run=0 at exec_done → IDLE, no request.
